// File: rtl/l2_vec_ctrl.sv
// Sequencing controller for the L2-norm datapath: accumulates the sum of squares of a
// byte vector, then runs a one-bit-per-cycle restoring square root and hands off the result.
module l2_vec_ctrl #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 16,
    parameter int ACC_W   = 20,
    parameter int ROOT_W  = 10,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ROOT_W-1:0] out_root,
    output logic [CNT_W-1:0]  out_len,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int ITER_W = $clog2(ROOT_W);

    typedef enum logic [1:0] {
        INIT,
        ACCUM,
        SQRT,
        OUT
    } state_t;

    state_t state, next_state;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  rad;
    logic [ACC_W-1:0]  sq;
    logic [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]  cnt;
    logic              err;
    logic [ROOT_W:0]   rem;
    logic [ROOT_W-1:0] root;
    logic [ITER_W-1:0] iter;
    logic [ROOT_W+2:0] shifted;
    logic [ROOT_W+2:0] sub;
    logic              ge;
    logic              room;
    logic              sqrt_done;
    logic              hs_in;
    logic              hs_out;

    assign sq        = ACC_W'(in_data) * ACC_W'(in_data);
    assign acc_sum   = acc + sq;
    assign room      = (cnt < CNT_W'(MAX_LEN));
    // The remainder never exceeds 2*root, so ROOT_W+1 bits hold it between iterations.
    assign shifted   = {rem, rad[ACC_W-1 -: 2]};
    assign sub       = {1'b0, root, 2'b01};
    assign ge        = (shifted >= sub);
    assign sqrt_done = (iter == ITER_W'(ROOT_W - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        hs_in      = 1'b0;
        hs_out     = 1'b0;
        case (state)
            INIT: begin
                next_state = ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                hs_in    = in_valid;
                if (in_valid && in_last) begin
                    next_state = SQRT;
                end
            end
            SQRT: begin
                if (sqrt_done) begin
                    next_state = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                hs_out    = out_ready;
                if (out_ready) begin
                    next_state = ACCUM;
                end
            end
            default: begin
                next_state = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            rad      <= '0;
            rem      <= '0;
            root     <= '0;
            iter     <= '0;
            out_root <= '0;
            out_len  <= '0;
            out_err  <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (hs_in) begin
                        if (room) begin
                            acc <= acc_sum;
                            cnt <= cnt + 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        // Radicand must include the final element when it was accepted.
                        if (in_last) begin
                            rad  <= room ? acc_sum : acc;
                            rem  <= '0;
                            root <= '0;
                            iter <= '0;
                        end
                    end
                end
                SQRT: begin
                    rem  <= ge ? (ROOT_W + 1)'(shifted - sub) : (ROOT_W + 1)'(shifted);
                    root <= {root[ROOT_W-2:0], ge};
                    rad  <= rad << 2;
                    iter <= iter + 1'b1;
                    if (sqrt_done) begin
                        out_root <= {root[ROOT_W-2:0], ge};
                        out_len  <= cnt;
                        out_err  <= err;
                    end
                end
                OUT: begin
                    if (hs_out) begin
                        acc <= '0;
                        cnt <= '0;
                        err <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_vec_ctrl.sv
// Bench for l2_vec_ctrl: a per-vector model (sum of squares, search-based integer sqrt)
// feeds a scoreboard that a negedge compare process checks against the DUT every cycle.
module tb_l2_vec_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [9:0] out_root;
    logic [4:0] out_len;
    logic       out_err;
    logic       out_valid;
    logic       out_ready = 1'b1;

    typedef struct {
        int root;
        int len;
        int err;
        int vcycle;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cycle = 0;
    int   ready_mode = 1;
    int   cur_sum = 0;
    int   cur_cnt = 0;
    int   cur_err = 0;
    logic prev_valid = 1'b0;
    logic bubble = 1'b0;

    l2_vec_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_root  (out_root),
        .out_len   (out_len),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // out_ready: 0 = random, 1 = always ready, 2 = stalled
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = ($urandom_range(0, 9) < 6);
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
    end

    function automatic int isqrt(input int s);
        int r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic timeoutFail(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: bound expired at cycle %0d", name, cycle);
    endtask

    // Drive one element; returns at the negedge after its handshake.
    task automatic applyStimulus(input logic [7:0] d, input logic last, output int hs_cycle);
        int t = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        hs_cycle = cycle;
        if (t >= 200) begin
            timeoutFail("send_timeout");
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        @(posedge clk);
        if (cur_cnt < 16) begin
            cur_sum += int'(d) * int'(d);
            cur_cnt++;
        end else begin
            cur_err = 1;
        end
        @(negedge clk);
        hs_cycle = cycle;
        if (last) begin
            sb.push_back('{root: isqrt(cur_sum), len: cur_cnt, err: cur_err, vcycle: cycle + 10});
            cur_sum = 0;
            cur_cnt = 0;
            cur_err = 0;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Idle cycles with junk on data/last, which the DUT must ignore.
    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            in_data = 8'($urandom);
            in_last = 1'($urandom);
            @(negedge clk);
        end
        in_last = 1'b0;
    endtask

    task automatic waitResult(input string name, input int root, input int len, input int err,
                              output int seen_cycle);
        int t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        seen_cycle = cycle;
        if (!out_valid) begin
            timeoutFail({name, "_timeout"});
            return;
        end
        checkOutput({name, "_root"}, int'(out_root), root);
        checkOutput({name, "_len"}, int'(out_len), len);
        checkOutput({name, "_err"}, int'(out_err), err);
    endtask

    task automatic sendVec(input int n, input int val);
        int hs;
        for (int i = 0; i < n; i++) applyStimulus(8'(val), (i == n - 1), hs);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            bubble     = 1'b0;
        end else begin
            if (bubble) begin
                checkOutput("bubble_out_valid", int'(out_valid), 0);
                checkOutput("bubble_in_ready", int'(in_ready), 1);
                bubble = 1'b0;
            end
            checkOutput("ready_valid_excl", int'(in_ready && out_valid), 0);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    timeoutFail("unexpected_result");
                end else begin
                    checkOutput("model_root", int'(out_root), sb[0].root);
                    checkOutput("model_len", int'(out_len), sb[0].len);
                    checkOutput("model_err", int'(out_err), sb[0].err);
                    if (!prev_valid) checkOutput("model_latency", cycle, sb[0].vcycle);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        bubble = 1'b1;
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        int hs, seen, t, n;
        $display("[TB] start");
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", int'(in_ready), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_root", int'(out_root), 0);
        checkOutput("rst_out_len", int'(out_len), 0);
        checkOutput("rst_out_err", int'(out_err), 0);
        #2 reset = 1'b0;
        @(negedge clk);
        checkOutput("init_to_accum", int'(in_ready), 1);

        applyStimulus(8'd3, 1'b1, hs);
        waitResult("single3", 3, 1, 0, seen);
        checkOutput("single3_latency", seen - hs, 10);

        applyStimulus(8'd3, 1'b0, hs);
        idle(2);
        applyStimulus(8'd4, 1'b1, hs);
        waitResult("vec34_gapped", 5, 2, 0, seen);

        sendVec(2, 1);
        waitResult("vec11_floor", 1, 2, 0, seen);

        sendVec(16, 255);
        waitResult("max16", 1020, 16, 0, seen);

        sendVec(17, 255);
        waitResult("over17", 1020, 16, 1, seen);
        applyStimulus(8'd6, 1'b0, hs);
        applyStimulus(8'd8, 1'b1, hs);
        waitResult("vec68_cleared", 10, 2, 0, seen);

        ready_mode = 2;
        applyStimulus(8'd12, 1'b0, hs);
        applyStimulus(8'd5, 1'b1, hs);
        waitResult("stall", 13, 2, 0, seen);
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_valid", int'(out_valid), 1);
            checkOutput("stall_in_ready", int'(in_ready), 0);
            checkOutput("stall_root", int'(out_root), 13);
        end
        ready_mode = 1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("release_valid", int'(out_valid), 0);
        checkOutput("release_in_ready", int'(in_ready), 1);

        applyStimulus(8'd9, 1'b1, hs);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        sb.delete();
        #1;
        checkOutput("abort_in_ready", int'(in_ready), 0);
        checkOutput("abort_out_valid", int'(out_valid), 0);
        checkOutput("abort_out_root", int'(out_root), 0);
        checkOutput("abort_out_len", int'(out_len), 0);
        checkOutput("abort_out_err", int'(out_err), 0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 checkOutput("post_rst_in_ready_low", int'(in_ready), 0);
        @(negedge clk);
        checkOutput("post_rst_in_ready", int'(in_ready), 1);
        applyStimulus(8'd5, 1'b1, hs);
        waitResult("after_abort", 5, 1, 0, seen);

        ready_mode = 0;
        for (int v = 0; v < 40; v++) begin
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                applyStimulus(($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255)),
                              (i == n - 1), hs);
            end
        end

        t = 0;
        while (sb.size() > 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() > 0) timeoutFail("drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule
